// File: rtl/pktarb_pkg.sv
// Shared types and default sizing for the packet arbiter slice.
// Holds the FSM encoding and the width defaults used by pktarb and its interface.
// No logic; imported by every other file of the block.
package pktarb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam int NUM_SRCS_DEF  = 8;
    localparam int LGSRCS        = $clog2(NUM_SRCS_DEF);
    localparam int LGWEIGHT_DEF  = 4;
    localparam int LGTIMEOUT_DEF = 10;

endpackage

// File: rtl/pktarb_if.sv
// Arbiter-to-datapath bundle: source requests/config in, grant and status out.
// master = arbiter side, slave = source/mux side.
// Pure wiring, no latency or flow control of its own.
interface pktarb_if #(
    parameter int NUM_SRCS = 8,
    parameter int LGWEIGHT = 4
);
    localparam int SRCW = $clog2(NUM_SRCS);

    logic [NUM_SRCS-1:0]          i_request;
    logic [NUM_SRCS-1:0]          i_enable;
    logic [NUM_SRCS*LGWEIGHT-1:0] i_weight;
    logic                         i_beat;
    logic                         i_last;
    logic [NUM_SRCS-1:0]          o_grant;
    logic [SRCW-1:0]              o_grant_index;
    logic                         o_busy;
    logic                         o_timeout;

    modport master (
        input  i_request, i_enable, i_weight, i_beat, i_last,
        output o_grant, o_grant_index, o_busy, o_timeout
    );

    modport slave (
        output i_request, i_enable, i_weight, i_beat, i_last,
        input  o_grant, o_grant_index, o_busy, o_timeout
    );

endinterface

// File: rtl/pktarb_rrpick.sv
// Rotating-priority pick: first set bit of eligible at or after start, wrapping.
// Purely combinational, zero latency.
// No flow control; found=0 when the mask is empty.
module pktarb_rrpick #(
    parameter int NUM_SRCS = 8,
    parameter int SRCW     = $clog2(NUM_SRCS)
) (
    input  logic [NUM_SRCS-1:0] eligible,
    input  logic [SRCW-1:0]     start,
    output logic                found,
    output logic [SRCW-1:0]     index
);

    int              pos;
    logic [SRCW-1:0] pos_idx;

    // Scan from the farthest offset back to start so the nearest hit wins.
    always_comb begin
        found   = 1'b0;
        index   = '0;
        pos     = 0;
        pos_idx = '0;
        for (int i = NUM_SRCS - 1; i >= 0; i--) begin
            pos = int'(start) + i;
            if (pos >= NUM_SRCS) begin
                pos = pos - NUM_SRCS;
            end
            pos_idx = SRCW'(pos);
            if (eligible[pos_idx]) begin
                found = 1'b1;
                index = pos_idx;
            end
        end
    end

endmodule

// File: rtl/pktarb.sv
// Weighted round-robin packet arbiter: grants one source per packet, holds until LAST.
// Latency: request-to-grant 1 cycle; 2 idle cycles between consecutive grants.
// Backpressure: grant held indefinitely while waiting for LAST (watchdog revoke when PKTARB_TIMEOUT_EN).
module pktarb
    import pktarb_pkg::*;
#(
    parameter int NUM_SRCS  = NUM_SRCS_DEF,
    parameter int LGWEIGHT  = LGWEIGHT_DEF,
    parameter int LGTIMEOUT = LGTIMEOUT_DEF
) (
    input  logic     S_AXI_ACLK,
    input  logic     S_AXI_ARESET,
    pktarb_if.master bus
);

    localparam int              SRCW     = $clog2(NUM_SRCS);
    localparam logic [SRCW-1:0] LAST_SRC = SRCW'(NUM_SRCS - 1);

    arb_state_t          state, state_nxt;
    logic [SRCW-1:0]     pointer, pointer_nxt;
    logic                skip_ptr, skip_ptr_nxt;     // pointer source used up its turn
    logic [LGWEIGHT-1:0] credit     [NUM_SRCS];
    logic [LGWEIGHT-1:0] credit_nxt [NUM_SRCS];
    logic [NUM_SRCS-1:0] grant, grant_nxt;
    logic [SRCW-1:0]     grant_idx, grant_idx_nxt;
    logic                busy, busy_nxt;

    logic [NUM_SRCS-1:0] eligible;
    logic [SRCW-1:0]     pick_start, pick_idx;
    logic                pick_found;
    logic [LGWEIGHT-1:0] pick_weight;
    logic                revoke;

    assign eligible    = bus.i_request & bus.i_enable;
    assign pick_start  = !skip_ptr ? pointer : ((pointer == LAST_SRC) ? '0 : pointer + 1'b1);
    assign pick_weight = bus.i_weight[int'(pick_idx) * LGWEIGHT +: LGWEIGHT];

    pktarb_rrpick #(
        .NUM_SRCS (NUM_SRCS),
        .SRCW     (SRCW)
    ) u_pick (
        .eligible (eligible),
        .start    (pick_start),
        .found    (pick_found),
        .index    (pick_idx)
    );

`ifdef PKTARB_TIMEOUT_EN
    localparam logic [LGTIMEOUT-1:0] WD_TRIP = LGTIMEOUT'((1 << LGTIMEOUT) - 2);

    logic [LGTIMEOUT-1:0] watchdog;
    logic                 timeout;

    // Count beat-less HOLD cycles; the step onto all-ones revokes the grant.
    assign revoke = (state == HOLD) && !bus.i_beat && (watchdog == WD_TRIP);

    // Watchdog counter and the one-cycle revoke pulse.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            watchdog <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= revoke;
            if (state != HOLD || bus.i_beat || revoke) begin
                watchdog <= '0;
            end else begin
                watchdog <= watchdog + 1'b1;
            end
        end
    end

    assign bus.o_timeout = timeout;
`else
    assign revoke        = 1'b0;
    assign bus.o_timeout = 1'b0;
`endif

    // Next-state, grant and credit bookkeeping.
    always_comb begin
        state_nxt     = state;
        pointer_nxt   = pointer;
        skip_ptr_nxt  = skip_ptr;
        credit_nxt    = credit;
        grant_nxt     = grant;
        grant_idx_nxt = grant_idx;
        busy_nxt      = busy;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_nxt           = '0;
                    grant_nxt[pick_idx] = 1'b1;
                    grant_idx_nxt       = pick_idx;
                    busy_nxt            = 1'b1;
                    state_nxt           = HOLD;
                    // Any new turn (different source, or same source with no
                    // credit left) moves the pointer and reloads the credit.
                    if (pick_idx != pointer || credit[pointer] == '0) begin
                        pointer_nxt          = pick_idx;
                        skip_ptr_nxt         = 1'b0;
                        credit_nxt[pick_idx] = (pick_weight == '0) ? LGWEIGHT'(1) : pick_weight;
                    end
                end
            end
            HOLD: begin
                if (revoke) begin
                    grant_nxt             = '0;
                    busy_nxt              = 1'b0;
                    credit_nxt[grant_idx] = '0;
                    skip_ptr_nxt          = 1'b1;
                    state_nxt             = GAP;
                end else if (bus.i_beat && bus.i_last) begin
                    grant_nxt = '0;
                    busy_nxt  = 1'b0;
                    state_nxt = GAP;
                    if (credit[grant_idx] != '0) begin
                        credit_nxt[grant_idx] = credit[grant_idx] - 1'b1;
                    end
                    if (credit[grant_idx] <= LGWEIGHT'(1)) begin
                        skip_ptr_nxt = 1'b1;
                    end
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, pointer, credits and registered grant outputs.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state     <= IDLE;
            pointer   <= '0;
            skip_ptr  <= 1'b0;
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            for (int k = 0; k < NUM_SRCS; k++) begin
                credit[k] <= '0;
            end
        end else begin
            state     <= state_nxt;
            pointer   <= pointer_nxt;
            skip_ptr  <= skip_ptr_nxt;
            grant     <= grant_nxt;
            grant_idx <= grant_idx_nxt;
            busy      <= busy_nxt;
            credit    <= credit_nxt;
        end
    end

    assign bus.o_grant       = grant;
    assign bus.o_grant_index = grant_idx;
    assign bus.o_busy        = busy;

endmodule

// File: tb/tb_pktarb.sv
// Directed bench for pktarb: reset, single source, weighted order, disable mask,
// mid-packet disturbance/reset and watchdog (or indefinite hold without it).
// Inputs driven 1 time unit after the rising edge; outputs sampled there too.
module tb_pktarb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pktarb_if #(.NUM_SRCS(8), .LGWEIGHT(4)) bus ();

    pktarb #(
        .NUM_SRCS  (8),
        .LGWEIGHT  (4),
        .LGTIMEOUT (4)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .bus          (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_request = '0;
        bus.i_beat    = 1'b0;
        bus.i_last    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(output logic [2:0] idx);
        int n;
        n = 0;
        while (!bus.o_busy && n < 40) begin
            tick();
            n++;
        end
        chk("grant_wait", 32'(bus.o_busy), 32'd1);
        idx = bus.o_grant_index;
    endtask

    task automatic end_pkt();
        bus.i_beat = 1'b1;
        bus.i_last = 1'b1;
        tick();
        bus.i_beat = 1'b0;
        bus.i_last = 1'b0;
    endtask

    int         exp_wrr [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int         exp_dis [5] = '{1, 3, 5, 7, 1};
    logic [2:0] idx;
    int         held_bad;

    initial begin
        bus.i_request = '0;
        bus.i_enable  = 8'hFF;
        bus.i_weight  = 32'h1111_1111;
        bus.i_beat    = 1'b0;
        bus.i_last    = 1'b0;
        #1;
        chk("rst_grant", 32'(bus.o_grant), 32'h0);
        chk("rst_index", 32'(bus.o_grant_index), 32'h0);
        chk("rst_busy", 32'(bus.o_busy), 32'h0);
        chk("rst_timeout", 32'(bus.o_timeout), 32'h0);
        do_reset();

        // Single source, 4-beat packet, then regrant after the gap.
        bus.i_request = 8'h04;
        tick();
        chk("single_grant", 32'(bus.o_grant), 32'h04);
        chk("single_index", 32'(bus.o_grant_index), 32'd2);
        bus.i_beat = 1'b1;
        for (int b = 0; b < 3; b++) begin
            tick();
            chk("single_hold", 32'(bus.o_grant), 32'h04);
        end
        bus.i_last = 1'b1;
        tick();
        bus.i_beat = 1'b0;
        bus.i_last = 1'b0;
        chk("single_drop", 32'(bus.o_grant), 32'h0);
        chk("single_drop_busy", 32'(bus.o_busy), 32'h0);
        tick();
        chk("single_gap2", 32'(bus.o_grant), 32'h0);
        tick();
        chk("single_regrant", 32'(bus.o_grant), 32'h04);
        end_pkt();

        // Weighted: src0 weight 3, src1 weight 1.
        do_reset();
        bus.i_weight  = 32'h0000_0013;
        bus.i_request = 8'h03;
        for (int p = 0; p < 8; p++) begin
            wait_grant(idx);
            chk("wrr_order", 32'(idx), 32'(exp_wrr[p]));
            end_pkt();
        end

        // Disable mask 0xAA, all weights 0 (act as 1).
        do_reset();
        bus.i_weight  = 32'h0;
        bus.i_request = 8'hFF;
        bus.i_enable  = 8'hAA;
        for (int p = 0; p < 5; p++) begin
            wait_grant(idx);
            chk("dis_order", 32'(idx), 32'(exp_dis[p]));
            chk("dis_onehot", 32'(bus.o_grant), 32'h1 << exp_dis[p]);
            end_pkt();
        end

        // Mid-packet: drop request/enable of granted source, others request.
        do_reset();
        bus.i_weight  = 32'h1111_1111;
        bus.i_enable  = 8'hFF;
        bus.i_request = 8'h20;
        tick();
        chk("mid_grant", 32'(bus.o_grant), 32'h20);
        bus.i_beat = 1'b1;
        tick();
        bus.i_request = 8'h02;
        bus.i_enable  = 8'hDF;
        tick();
        chk("mid_hold1", 32'(bus.o_grant), 32'h20);
        tick();
        chk("mid_hold2", 32'(bus.o_grant), 32'h20);
        bus.i_last = 1'b1;
        tick();
        bus.i_beat = 1'b0;
        bus.i_last = 1'b0;
        chk("mid_release", 32'(bus.o_grant), 32'h0);
        end_pkt();
        chk("mid_beat_ignored", 32'(bus.o_busy), 32'h0);

        // Reset asserted in the middle of a packet.
        do_reset();
        bus.i_enable  = 8'hFF;
        bus.i_request = 8'h20;
        wait_grant(idx);
        bus.i_beat = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_grant", 32'(bus.o_grant), 32'h0);
        chk("mid_rst_busy", 32'(bus.o_busy), 32'h0);
        chk("mid_rst_index", 32'(bus.o_grant_index), 32'h0);
        do_reset();

`ifdef PKTARB_TIMEOUT_EN
        // Watchdog: one beat, then silence; revoke 15 cycles after that beat.
        bus.i_request = 8'h08;
        tick();
        chk("wd_grant", 32'(bus.o_grant), 32'h08);
        bus.i_beat = 1'b1;
        tick();
        bus.i_beat = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
        end
        chk("wd_busy14", 32'(bus.o_busy), 32'h1);
        chk("wd_quiet14", 32'(bus.o_timeout), 32'h0);
        tick();
        chk("wd_revoke", 32'(bus.o_grant), 32'h0);
        chk("wd_pulse", 32'(bus.o_timeout), 32'h1);
        tick();
        chk("wd_pulse_end", 32'(bus.o_timeout), 32'h0);
`else
        // Without the watchdog the grant is held for as long as LAST is absent.
        bus.i_request = 8'h08;
        tick();
        chk("hold_grant", 32'(bus.o_grant), 32'h08);
        held_bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.o_grant !== 8'h08 || bus.o_timeout !== 1'b0) held_bad++;
        end
        chk("hold100", 32'(held_bad), 32'd0);
        end_pkt();
        chk("hold_release", 32'(bus.o_grant), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
